// File: rtl/core_run_controller_if.sv
// Host command channel for core_run_controller: valid/ready strobe plus opcode,
// breakpoint slot, argument and a one-cycle error response.
interface core_run_controller_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_WIDTH  = 2
);
  // A command transfers on any posedge where cmd_valid && cmd_ready; the host holds
  // op/index/arg stable while cmd_valid is high, and cmd_error answers one cycle later.
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_op;
  logic [IDX_WIDTH-1:0]  cmd_index;
  logic [ADDR_WIDTH-1:0] cmd_arg;
  logic                  cmd_error;

  modport master (
    output cmd_valid, cmd_op, cmd_index, cmd_arg,
    input  cmd_ready, cmd_error
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_index, cmd_arg,
    output cmd_ready, cmd_error
  );
endinterface

// File: rtl/core_run_controller.sv
// Run/halt/step controller for a processor core: drives a per-cycle core clock-enable,
// PC breakpoints, a retired-instruction counter and an external-memory grant.
module core_run_controller #(
  parameter int ADDR_WIDTH      = 32,
  parameter int NUM_BREAKPOINTS = 4,
  parameter int STEP_WIDTH      = 16,
  parameter bit START_RUNNING   = 1'b1,
  localparam int IDX_WIDTH      = (NUM_BREAKPOINTS > 1) ? $clog2(NUM_BREAKPOINTS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  core_run_controller_if.slave   cmd,
  input  logic [ADDR_WIDTH-1:0]  pc_address,
  output logic                   core_enable,
  output logic                   ext_mem_grant,
  output logic                   halted,
  output logic [1:0]             halt_reason,
  output logic [IDX_WIDTH-1:0]   bp_hit_index,
  output logic [31:0]            retired_count,
  output logic [1:0]             dbgState
);

  typedef enum logic [1:0] {
    S_HALTED   = 2'd0,
    S_RUNNING  = 2'd1,
    S_STEPPING = 2'd2,
    S_EXT_MEM  = 2'd3
  } state_t;

  localparam logic [2:0] OP_RUN     = 3'd0;
  localparam logic [2:0] OP_HALT    = 3'd1;
  localparam logic [2:0] OP_STEP    = 3'd2;
  localparam logic [2:0] OP_SET_BP  = 3'd3;
  localparam logic [2:0] OP_CLR_BP  = 3'd4;
  localparam logic [2:0] OP_MEM_REQ = 3'd5;
  localparam logic [2:0] OP_MEM_REL = 3'd6;

  localparam logic [1:0] REASON_HALT = 2'd1;
  localparam logic [1:0] REASON_BP   = 2'd2;
  localparam logic [1:0] REASON_STEP = 2'd3;

  localparam state_t RESET_STATE = START_RUNNING ? S_RUNNING : S_HALTED;

  state_t                 state, stateNext;
  logic [STEP_WIDTH-1:0]  stepsLeft, stepsNext, stepLoad;
  logic                   skipBp, skipNext;
  logic [1:0]             haltReason, reasonNext;
  logic [IDX_WIDTH-1:0]   bpHitIdx, hitNext;
  logic [31:0]            retiredCnt;
  logic                   cmdReady, cmdErrorQ, errNext;
  logic [NUM_BREAKPOINTS-1:0] bpEn;
  logic [ADDR_WIDTH-1:0]  bpAddr [NUM_BREAKPOINTS];

  logic                   cmdAccept, cmdLegal, idxInRange, bpWrite;
  logic                   bpMatch, coreEnable;
  logic [IDX_WIDTH-1:0]   bpIdx;

  assign cmdAccept  = cmd.cmd_valid && cmdReady;
  assign idxInRange = int'(cmd.cmd_index) < NUM_BREAKPOINTS;
  assign bpWrite    = cmdAccept && idxInRange &&
                      (cmd.cmd_op == OP_SET_BP || cmd.cmd_op == OP_CLR_BP);

  // A step count of zero still executes one instruction.
  always_comb begin
    stepLoad = cmd.cmd_arg[STEP_WIDTH-1:0];
    if (stepLoad == '0) stepLoad = STEP_WIDTH'(1);
  end

  // Scanning from the top down leaves the lowest matching slot in bpIdx.
  always_comb begin
    bpMatch = 1'b0;
    bpIdx   = '0;
    for (int i = NUM_BREAKPOINTS - 1; i >= 0; i--) begin
      if (bpEn[i] && bpAddr[i] == pc_address) begin
        bpMatch = 1'b1;
        bpIdx   = IDX_WIDTH'(i);
      end
    end
  end

  always_comb begin
    case (state)
      S_RUNNING:  coreEnable = !bpMatch || skipBp;
      S_STEPPING: coreEnable = 1'b1;
      default:    coreEnable = 1'b0;
    endcase
  end

  always_comb begin
    case (cmd.cmd_op)
      OP_RUN, OP_STEP, OP_MEM_REQ: cmdLegal = (state == S_HALTED);
      OP_HALT:                     cmdLegal = (state == S_RUNNING) || (state == S_STEPPING);
      OP_SET_BP, OP_CLR_BP:        cmdLegal = idxInRange;
      OP_MEM_REL:                  cmdLegal = (state == S_EXT_MEM);
      default:                     cmdLegal = 1'b0;
    endcase
  end

  always_comb begin
    stateNext  = state;
    stepsNext  = stepsLeft;
    skipNext   = skipBp;
    reasonNext = haltReason;
    hitNext    = bpHitIdx;
    errNext    = cmdAccept && !cmdLegal;
    if (coreEnable) skipNext = 1'b0;
    case (state)
      S_RUNNING: begin
        // Breakpoint outranks a HALT command arriving in the same cycle.
        if (bpMatch && !skipBp) begin
          stateNext  = S_HALTED;
          reasonNext = REASON_BP;
          hitNext    = bpIdx;
        end else if (cmdAccept && cmd.cmd_op == OP_HALT) begin
          stateNext  = S_HALTED;
          reasonNext = REASON_HALT;
        end
      end
      S_STEPPING: begin
        if (stepsLeft <= STEP_WIDTH'(1)) begin
          stateNext  = S_HALTED;
          stepsNext  = '0;
          reasonNext = REASON_STEP;
        end else begin
          stepsNext = stepsLeft - STEP_WIDTH'(1);
          if (cmdAccept && cmd.cmd_op == OP_HALT) begin
            stateNext  = S_HALTED;
            reasonNext = REASON_HALT;
          end
        end
      end
      S_HALTED: begin
        if (cmdAccept) begin
          case (cmd.cmd_op)
            OP_RUN: begin
              stateNext = S_RUNNING;
              skipNext  = 1'b1;
            end
            OP_STEP: begin
              stateNext = S_STEPPING;
              stepsNext = stepLoad;
            end
            OP_MEM_REQ: stateNext = S_EXT_MEM;
            default: ;
          endcase
        end
      end
      S_EXT_MEM: begin
        if (cmdAccept && cmd.cmd_op == OP_MEM_REL) stateNext = S_HALTED;
      end
      default: stateNext = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RESET_STATE;
      stepsLeft  <= '0;
      skipBp     <= 1'b0;
      haltReason <= 2'd0;
      bpHitIdx   <= '0;
      retiredCnt <= 32'd0;
      cmdReady   <= 1'b0;
      cmdErrorQ  <= 1'b0;
      bpEn       <= '0;
      for (int i = 0; i < NUM_BREAKPOINTS; i++) bpAddr[i] <= '0;
    end else begin
      state      <= stateNext;
      stepsLeft  <= stepsNext;
      skipBp     <= skipNext;
      haltReason <= reasonNext;
      bpHitIdx   <= hitNext;
      cmdReady   <= 1'b1;
      cmdErrorQ  <= errNext;
      if (coreEnable) retiredCnt <= retiredCnt + 32'd1;
      for (int i = 0; i < NUM_BREAKPOINTS; i++) begin
        if (bpWrite && cmd.cmd_index == IDX_WIDTH'(i)) begin
          bpEn[i] <= (cmd.cmd_op == OP_SET_BP);
          if (cmd.cmd_op == OP_SET_BP) bpAddr[i] <= cmd.cmd_arg;
        end
      end
    end
  end

  assign core_enable   = coreEnable;
  assign ext_mem_grant = (state == S_EXT_MEM);
  assign halted        = (state == S_HALTED) || (state == S_EXT_MEM);
  assign halt_reason   = haltReason;
  assign bp_hit_index  = bpHitIdx;
  assign retired_count = retiredCnt;
  assign cmd.cmd_ready = cmdReady;
  assign cmd.cmd_error = cmdErrorQ;
  assign dbgState      = state;

endmodule

// File: tb/tb_core_run_controller.sv
// Bench for core_run_controller: directed scenarios followed by random commands, all
// checked every cycle against a behavioural model of the run controller and a simple core PC.
module tb_core_run_controller;
  localparam int AW  = 32;
  localparam int NBP = 5;
  localparam int SW  = 16;
  localparam int IW  = 3;

  localparam int M_HALT = 0, M_RUN = 1, M_STEP = 2, M_EXT = 3;
  localparam logic [2:0] RUN = 3'd0, HALT = 3'd1, STEP = 3'd2, SETBP = 3'd3,
                         CLRBP = 3'd4, MREQ = 3'd5, MREL = 3'd6, RSVD = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  core_run_controller_if #(.ADDR_WIDTH(AW), .IDX_WIDTH(IW)) cmdIf ();
  logic [AW-1:0] pc_address;
  logic          core_enable, ext_mem_grant, halted;
  logic [1:0]    halt_reason;
  logic [IW-1:0] bp_hit_index;
  logic [31:0]   retired_count;
  logic [1:0]    dbgState;

  core_run_controller #(
    .ADDR_WIDTH(AW), .NUM_BREAKPOINTS(NBP), .STEP_WIDTH(SW), .START_RUNNING(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .cmd(cmdIf),
    .pc_address(pc_address), .core_enable(core_enable), .ext_mem_grant(ext_mem_grant),
    .halted(halted), .halt_reason(halt_reason), .bp_hit_index(bp_hit_index),
    .retired_count(retired_count), .dbgState(dbgState)
  );

  int nAssert = 0;
  int nFail   = 0;
  int enCount = 0;
  bit pcJumpy = 0;

  // Reference model state
  int            mMode;
  int            mSteps;
  bit            mSkip, mErr, mReady;
  logic [31:0]   mRet;
  logic [1:0]    mReason;
  logic [IW-1:0] mHit;
  logic [AW-1:0] mPc;
  bit            mBpEn [NBP];
  logic [AW-1:0] mBpAddr [NBP];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mMode = M_RUN; mSteps = 0; mSkip = 0; mErr = 0; mReady = 0;
    mRet = 0; mReason = 0; mHit = 0; mPc = 0;
    for (int i = 0; i < NBP; i++) begin
      mBpEn[i] = 0; mBpAddr[i] = 0;
    end
  endtask

  function automatic void model_match(output bit m, output logic [IW-1:0] ix);
    m = 0; ix = 0;
    for (int i = 0; i < NBP; i++) begin
      if (!m && mBpEn[i] && mBpAddr[i] == mPc) begin
        m = 1; ix = IW'(i);
      end
    end
  endfunction

  function automatic bit exp_enable();
    bit m; logic [IW-1:0] ix;
    model_match(m, ix);
    return (mMode == M_RUN && (!m || mSkip)) || (mMode == M_STEP);
  endfunction

  task automatic model_update(bit v, logic [2:0] op, logic [IW-1:0] idx, logic [AW-1:0] arg);
    bit m, en, acc, legal, blocked; logic [IW-1:0] ix;
    model_match(m, ix);
    en      = exp_enable();
    blocked = m && !mSkip;
    acc     = v && mReady;
    if (op == RUN || op == STEP || op == MREQ) legal = (mMode == M_HALT);
    else if (op == HALT)                       legal = (mMode == M_RUN || mMode == M_STEP);
    else if (op == SETBP || op == CLRBP)       legal = (int'(idx) < NBP);
    else if (op == MREL)                       legal = (mMode == M_EXT);
    else                                       legal = 0;
    mErr = acc && !legal;
    if (en) begin
      mRet = mRet + 1;
      mSkip = 0;
      if (pcJumpy && $urandom_range(0, 7) == 0) mPc = AW'($urandom_range(0, 63) * 4);
      else mPc = (mPc + 4) & 32'hFF;
    end
    if (mMode == M_RUN) begin
      if (blocked) begin mMode = M_HALT; mReason = 2; mHit = ix; end
      else if (acc && op == HALT) begin mMode = M_HALT; mReason = 1; end
    end else if (mMode == M_STEP) begin
      if (mSteps <= 1) begin mMode = M_HALT; mReason = 3; mSteps = 0; end
      else begin
        mSteps--;
        if (acc && op == HALT) begin mMode = M_HALT; mReason = 1; end
      end
    end else if (mMode == M_HALT) begin
      if (acc && op == RUN) begin mMode = M_RUN; mSkip = 1; end
      else if (acc && op == STEP) begin
        mMode = M_STEP;
        mSteps = (arg[SW-1:0] == 0) ? 1 : int'(arg[SW-1:0]);
      end else if (acc && op == MREQ) mMode = M_EXT;
    end else if (acc && op == MREL) mMode = M_HALT;
    if (acc && legal && op == SETBP) begin mBpEn[idx] = 1; mBpAddr[idx] = arg; end
    if (acc && legal && op == CLRBP) mBpEn[idx] = 0;
    mReady = 1;
  endtask

  task automatic check_all();
    chk("enable",  32'(core_enable),   32'(exp_enable()));
    chk("halted",  32'(halted),        32'(mMode == M_HALT || mMode == M_EXT));
    chk("grant",   32'(ext_mem_grant), 32'(mMode == M_EXT));
    chk("error",   32'(cmdIf.cmd_error), 32'(mErr));
    chk("ready",   32'(cmdIf.cmd_ready), 32'(mReady));
    chk("reason",  32'(halt_reason),   32'(mReason));
    chk("hit_idx", 32'(bp_hit_index),  32'(mHit));
    chk("retired", retired_count,      mRet);
  endtask

  task automatic cycle(bit v, logic [2:0] op, logic [IW-1:0] idx, logic [AW-1:0] arg);
    cmdIf.cmd_valid = v; cmdIf.cmd_op = op; cmdIf.cmd_index = idx; cmdIf.cmd_arg = arg;
    pc_address = mPc;
    #1;
    check_all();
    if (core_enable === 1'b1) enCount++;
    @(posedge clk);
    model_update(v, op, idx, arg);
    @(negedge clk);
    cmdIf.cmd_valid = 1'b0;
    pc_address = mPc;
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) cycle(1'b0, RUN, '0, '0);
  endtask

  task automatic check_reset_vals(string ctx);
    chk({ctx, ".grant"},   32'(ext_mem_grant),   32'd0);
    chk({ctx, ".halted"},  32'(halted),          32'd0);
    chk({ctx, ".retired"}, retired_count,        32'd0);
    chk({ctx, ".reason"},  32'(halt_reason),     32'd0);
    chk({ctx, ".hit"},     32'(bp_hit_index),    32'd0);
    chk({ctx, ".error"},   32'(cmdIf.cmd_error), 32'd0);
    chk({ctx, ".ready"},   32'(cmdIf.cmd_ready), 32'd0);
  endtask

  // Reset pulled mid-cycle: outputs must fall back without waiting for a clock edge.
  task automatic reset_mid(string ctx);
    #2 rst = 1'b0;
    #1 check_reset_vals(ctx);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    pc_address = mPc;
    #1;
  endtask

  task automatic run_to_pc(logic [AW-1:0] target);
    int k;
    k = 0;
    while (mPc != target && k < 80) begin
      idle(1);
      k++;
    end
    chk("reach_pc.bound", 32'(k < 80), 32'd1);
  endtask

  initial begin
    logic [AW-1:0] tgt;
    cmdIf.cmd_valid = 1'b0; cmdIf.cmd_op = RUN; cmdIf.cmd_index = '0; cmdIf.cmd_arg = '0;
    model_reset();
    pc_address = mPc;
    #12 check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b1;
    #1;

    // Free-running after reset
    idle(10);
    chk("free_run.retired", retired_count, 32'd10);
    chk("free_run.halted", 32'(halted), 32'd0);

    // Breakpoint at 0x40 in slot 2, then resume over it
    cycle(1'b1, SETBP, 3'd2, 32'h40);
    run_to_pc(32'h40);
    chk("bp.enable_at_hit", 32'(core_enable), 32'd0);
    idle(1);
    chk("bp.halted", 32'(halted), 32'd1);
    chk("bp.reason", 32'(halt_reason), 32'd2);
    chk("bp.hit_idx", 32'(bp_hit_index), 32'd2);
    cycle(1'b1, RUN, '0, '0);
    enCount = 0;
    idle(3);
    chk("resume.count", 32'(enCount), 32'd3);
    chk("resume.halted", 32'(halted), 32'd0);

    // Stepping
    cycle(1'b1, HALT, '0, '0);
    chk("halt.reason", 32'(halt_reason), 32'd1);
    enCount = 0;
    cycle(1'b1, STEP, '0, 32'd3);
    idle(6);
    chk("step3.count", 32'(enCount), 32'd3);
    chk("step3.reason", 32'(halt_reason), 32'd3);
    chk("step3.halted", 32'(halted), 32'd1);
    enCount = 0;
    cycle(1'b1, STEP, '0, 32'hABCD_0000);
    idle(4);
    chk("step0.count", 32'(enCount), 32'd1);

    // External memory handover
    cycle(1'b1, RUN, '0, '0);
    cycle(1'b1, MREQ, '0, '0);
    chk("mreq_running.error", 32'(cmdIf.cmd_error), 32'd1);
    chk("mreq_running.halted", 32'(halted), 32'd0);
    idle(1);
    cycle(1'b1, HALT, '0, '0);
    cycle(1'b1, MREQ, '0, '0);
    chk("mreq.grant", 32'(ext_mem_grant), 32'd1);
    chk("mreq.enable", 32'(core_enable), 32'd0);
    cycle(1'b1, MREL, '0, '0);
    chk("mrel.grant", 32'(ext_mem_grant), 32'd0);
    chk("mrel.halted", 32'(halted), 32'd1);
    chk("mrel.reason", 32'(halt_reason), 32'd1);

    // Out-of-range slot, then HALT colliding with a breakpoint
    cycle(1'b1, SETBP, 3'd5, 32'h10);
    chk("bad_idx.error", 32'(cmdIf.cmd_error), 32'd1);
    idle(1);
    chk("bad_idx.error_drop", 32'(cmdIf.cmd_error), 32'd0);
    tgt = (mPc + 32'd12) & 32'hFF;
    cycle(1'b1, SETBP, 3'd0, tgt);
    cycle(1'b1, RUN, '0, '0);
    run_to_pc(tgt);
    cycle(1'b1, HALT, '0, '0);
    chk("halt_vs_bp.reason", 32'(halt_reason), 32'd2);
    chk("halt_vs_bp.hit", 32'(bp_hit_index), 32'd0);

    // Reset during EXT_MEM; breakpoints must be gone afterwards
    cycle(1'b1, MREQ, '0, '0);
    chk("ext.grant", 32'(ext_mem_grant), 32'd1);
    reset_mid("rst_ext");
    chk("rst_ext.retired_after", retired_count, 32'd0);
    idle(24);
    chk("rst_ext.bp_cleared", 32'(halted), 32'd0);

    // Reset during a long step
    cycle(1'b1, HALT, '0, '0);
    cycle(1'b1, STEP, '0, 32'd100);
    idle(3);
    reset_mid("rst_step");
    idle(2);

    // Random commands with a wandering PC
    pcJumpy = 1;
    for (int n = 0; n < 500; n++) begin
      logic [2:0] op; logic [IW-1:0] ix; logic [AW-1:0] arg; bit v;
      v   = ($urandom_range(0, 9) < 4);
      op  = 3'($urandom_range(0, 7));
      ix  = IW'($urandom_range(0, 7));
      if (op == STEP) arg = ($urandom() & 32'hFFFF_0000) | 32'($urandom_range(0, 5));
      else            arg = 32'($urandom_range(0, 63) * 4);
      cycle(v, op, ix, arg);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
